// File: rtl/am_env_demod_if.sv
// Sample/envelope bundle between an AM sample source and am_env_demod.
// Ports: clr, in_valid, am_in (source -> demod); env_out, env_valid, win_full (demod -> sink).
// With AM_DC_BLOCK_EN defined the bundle also carries the signed DC-removed envelope dc_out.
interface am_env_demod_if;
  logic              clr;
  logic              in_valid;
  logic [7:0]        am_in;
  logic [7:0]        env_out;
  logic              env_valid;
  logic              win_full;
`ifdef AM_DC_BLOCK_EN
  logic signed [7:0] dc_out;

  modport master (
    output clr, in_valid, am_in,
    input  env_out, env_valid, win_full, dc_out
  );
  modport slave (
    input  clr, in_valid, am_in,
    output env_out, env_valid, win_full, dc_out
  );
`else
  modport master (
    output clr, in_valid, am_in,
    input  env_out, env_valid, win_full
  );
  modport slave (
    input  clr, in_valid, am_in,
    output env_out, env_valid, win_full
  );
`endif
endinterface

// File: rtl/am_env_demod.sv
// Envelope AM demodulator: full-wave rectify, then a 2^LOG2_WIN boxcar average scaled x2.
// Latency 3 cycles from accepted sample to env_valid; 1 sample/clk, no backpressure (stalls on in_valid gaps).
// Ports: clk, rst_n (async active-low), bus (am_env_demod_if.slave: clr, in_valid, am_in, env_out,
// env_valid, win_full). Optional DC blocker on dc_out when macro AM_DC_BLOCK_EN is defined.
module am_env_demod #(
  parameter int LOG2_WIN = 7,   // window = 2^LOG2_WIN samples, 2..10
  parameter int DC_SHIFT = 10   // DC blocker time-constant shift (AM_DC_BLOCK_EN only)
) (
  input  logic           clk,
  input  logic           rst_n,
  am_env_demod_if.slave  bus
);

  localparam int WIN   = 1 << LOG2_WIN;
  localparam int SUM_W = 7 + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;

  // ---------------- stage 1: rectify ----------------
  logic [7:0] abs8;
  logic [6:0] mag_d, mag_q;
  logic       v1_q;

  always_comb begin
    abs8 = bus.am_in[7] ? (~bus.am_in + 8'd1) : bus.am_in;
    // Only -128 produces a set MSB after negation; clamp it to 127.
    mag_d = abs8[7] ? 7'd127 : abs8[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
      v1_q  <= 1'b0;
    end else if (bus.clr) begin
      v1_q  <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) mag_q <= mag_d;
    end
  end

  // ---------------- stage 2: ring buffer + running sum ----------------
  logic [6:0]          ring_q [WIN];
  logic [6:0]          ring_old;
  logic [LOG2_WIN-1:0] wptr_q;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                win_full;
  logic                v2_q;

  // fill saturates at exactly WIN, so equality marks a full window.
  assign win_full = (fill_q == CNT_W'(WIN));
  assign ring_old = ring_q[wptr_q];

  always_comb begin
    // Until the window is full the slot being overwritten holds nothing valid.
    sum_d  = sum_q + SUM_W'(mag_q) - (win_full ? SUM_W'(ring_old) : '0);
    fill_d = win_full ? fill_q : fill_q + CNT_W'(1);
  end

  // Ring contents need no reset: a slot is always written before it is read.
  always_ff @(posedge clk) begin
    if (v1_q && !bus.clr) ring_q[wptr_q] <= mag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      v2_q   <= 1'b0;
    end else if (bus.clr) begin
      sum_q  <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      v2_q   <= 1'b0;
    end else if (v1_q) begin
      sum_q  <= sum_d;
      wptr_q <= wptr_q + 1'b1;   // power-of-two window wraps naturally
      fill_q <= fill_d;
      v2_q   <= (fill_d == CNT_W'(WIN));
    end else begin
      v2_q   <= 1'b0;
    end
  end

  // ---------------- stage 3: scale and register output ----------------
  logic [7:0] env_d, env_out_q;
  logic       env_valid_q;

  // sum >> (LOG2_WIN-1) is exactly the top 8 bits of the sum: mean x2.
  assign env_d = sum_q[SUM_W-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_out_q   <= '0;
      env_valid_q <= 1'b0;
    end else if (bus.clr) begin
      env_valid_q <= 1'b0;          // env_out holds across a flush
    end else begin
      env_valid_q <= v2_q;
      if (v2_q) env_out_q <= env_d;
    end
  end

  assign bus.env_out   = env_out_q;
  assign bus.env_valid = env_valid_q;
  assign bus.win_full  = win_full;

`ifdef AM_DC_BLOCK_EN
  // ---------------- optional DC blocker ----------------
  localparam int EST_W = 8 + DC_SHIFT;

  logic [EST_W-1:0]         dc_est_q, dc_est_d;
  logic signed [EST_W+1:0]  dc_err;
  logic signed [9:0]        dc_diff;
  logic signed [7:0]        dc_sat, dc_out_q;

  always_comb begin
    // dc_est is fixed-point with DC_SHIFT fraction bits; step is error / 2^DC_SHIFT.
    dc_err   = $signed({2'b00, env_d, {DC_SHIFT{1'b0}}}) - $signed({2'b00, dc_est_q});
    dc_est_d = dc_est_q + EST_W'(dc_err >>> DC_SHIFT);
    // Output uses the new envelope against the estimate before this update.
    dc_diff  = $signed({2'b00, env_d}) - $signed({2'b00, dc_est_q[EST_W-1 -: 8]});
    if (dc_diff > 10'sd127)       dc_sat = 8'sd127;
    else if (dc_diff < -10'sd128) dc_sat = -8'sd128;
    else                          dc_sat = dc_diff[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_est_q <= '0;
      dc_out_q <= '0;
    end else if (bus.clr) begin
      dc_est_q <= '0;
      dc_out_q <= '0;
    end else if (v2_q) begin
      dc_est_q <= dc_est_d;
      dc_out_q <= dc_sat;
    end
  end

  assign bus.dc_out = dc_out_q;
`endif

endmodule

// File: tb/tb_am_env_demod.sv
// Directed bench for am_env_demod with a 128-sample window.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_am_env_demod;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  am_env_demod_if bus();

  am_env_demod #(.LOG2_WIN(7), .DC_SHIFT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int strobes;
  int smin;
  int smax;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    strobes = 0;
    smin    = 1000;
    smax    = -1;
  endtask

  // One clock cycle with the given inputs; afterwards records any strobe.
  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    bus.in_valid = v;
    bus.am_in    = d;
    bus.clr      = c;
    @(posedge clk);
    #1;
    if (bus.env_valid === 1'b1) begin
      strobes++;
      if (int'(bus.env_out) < smin) smin = int'(bus.env_out);
      if (int'(bus.env_out) > smax) smax = int'(bus.env_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.am_in    = 8'd0;
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_env_out", 32'(bus.env_out), 0);
    check("rst_env_valid", 32'(bus.env_valid), 0);
    check("rst_win_full", 32'(bus.win_full), 0);
    rst_n = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);

    // Test 1: constant 100 -> envelope 200, first strobe 3 cycles after 128th sample
    clear_stats();
    for (int i = 0; i < 128; i++) cyc(1'b1, 8'd100, 1'b0);
    check("t1_no_strobe_in_fill", 32'(strobes), 0);
    check("t1_win_full_not_yet", 32'(bus.win_full), 0);
    cyc(1'b1, 8'd100, 1'b0);
    check("t1_win_full", 32'(bus.win_full), 1);
    check("t1_valid_t+2", 32'(bus.env_valid), 0);
    cyc(1'b1, 8'd100, 1'b0);
    check("t1_valid_t+3", 32'(bus.env_valid), 1);
    check("t1_env_first", 32'(bus.env_out), 200);
    clear_stats();
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'd100, 1'b0);
    check("t1_strobe_per_sample", 32'(strobes), 10);
    check("t1_env_min", 32'(smin), 200);
    check("t1_env_max", 32'(smax), 200);

    // Test 2: flush, then -128 saturates to 127 -> 254
    cyc(1'b0, 8'd0, 1'b1);
    check("t2_clr_win_full", 32'(bus.win_full), 0);
    check("t2_clr_valid", 32'(bus.env_valid), 0);
    check("t2_clr_env_hold", 32'(bus.env_out), 200);
    clear_stats();
    for (int i = 0; i < 200; i++) cyc(1'b1, 8'h80, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    check("t2_strobes", 32'(strobes), 73);
    check("t2_env_min", 32'(smin), 254);
    check("t2_env_max", 32'(smax), 254);

    // Test 3: +64/-64 on every other cycle -> 128, strobe exactly 3 cycles after each accept
    cyc(1'b0, 8'd0, 1'b1);
    clear_stats();
    for (int n = 0; n < 284; n++) begin
      logic v;
      logic [7:0] d;
      logic exp_v;
      v = ((n % 2) == 0) && (n / 2 < 140);
      d = (((n / 2) % 2) == 1) ? 8'hC0 : 8'h40;
      cyc(v, d, 1'b0);
      exp_v = ((n % 2) == 0) && (n >= 256) && (n <= 280);
      if (n >= 250) check($sformatf("t3_strobe_n%0d", n), 32'(bus.env_valid), 32'(exp_v));
    end
    check("t3_strobes", 32'(strobes), 13);
    check("t3_env_min", 32'(smin), 128);
    check("t3_env_max", 32'(smax), 128);

    // Test 4: clr with a coincident valid sample drops that sample
    cyc(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 128; i++) cyc(1'b1, 8'd100, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    check("t4_pre_valid", 32'(bus.env_valid), 1);
    check("t4_pre_env", 32'(bus.env_out), 200);
    cyc(1'b1, 8'h80, 1'b1);
    check("t4_clr_win_full", 32'(bus.win_full), 0);
    check("t4_clr_valid", 32'(bus.env_valid), 0);
    check("t4_clr_env_hold", 32'(bus.env_out), 200);
    clear_stats();
    for (int i = 0; i < 127; i++) cyc(1'b1, 8'd50, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    check("t4_127_no_strobe", 32'(strobes), 0);
    check("t4_127_not_full", 32'(bus.win_full), 0);
    check("t4_127_env_hold", 32'(bus.env_out), 200);
    cyc(1'b1, 8'd50, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    check("t4_128_full", 32'(bus.win_full), 1);
    cyc(1'b0, 8'd0, 1'b0);
    check("t4_128_valid", 32'(bus.env_valid), 1);
    check("t4_128_env", 32'(bus.env_out), 100);
    check("t4_128_strobes", 32'(strobes), 1);

    // Test 5: asynchronous reset mid-stream, then a clean refill
    for (int i = 0; i < 50; i++) cyc(1'b1, 8'd30, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("t5_rst_env_out", 32'(bus.env_out), 0);
    check("t5_rst_valid", 32'(bus.env_valid), 0);
    check("t5_rst_win_full", 32'(bus.win_full), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 128; i++) cyc(1'b1, 8'hEC, 1'b0);   // -20 -> magnitude 20
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    check("t5_refill_strobes", 32'(strobes), 1);
    check("t5_refill_env", 32'(bus.env_out), 40);
    check("t5_refill_full", 32'(bus.win_full), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/am_env_demod.md
Name: am_env_demod

Overview:
- Envelope-detecting AM demodulator; the receive-side counterpart of the cosine/DDS AM modulation path.
- Accepts signed 8-bit AM samples at up to one per clk.
- Full-wave rectifies each sample, then low-pass filters it with a power-of-two boxcar (ring buffer plus running sum).
- Emits a recovered unsigned 8-bit baseband stream with a valid strobe, for the DAC or a downstream checker.

Parameters:
- LOG2_WIN, 7, log2 of moving-average window length; WIN = 2^LOG2_WIN samples; legal range 2..10.
- DC_SHIFT, 10, IIR time-constant shift for the optional DC blocker (only used when AM_DC_BLOCK_EN is defined).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush: empties window, drops in-flight samples.
- in_valid  in  1  am_in carries a new sample this cycle.
- am_in  in  8  signed AM sample, two's complement.
- env_out  out  8  unsigned recovered envelope, 0..254.
- env_valid  out  1  one-cycle strobe; env_out is new this cycle.
- win_full  out  1  high once WIN samples have been accepted since reset or clr.
- dc_out  out  8  signed DC-removed envelope; present only with AM_DC_BLOCK_EN.

Behaviour:
- Reset (rst_n=0): all outputs are 0; sum, wptr, fill_cnt and pipeline valids are 0. Ring buffer contents are don't-care (never read before being written).
- Stage 1, cycle after in_valid:
  - mag_r <= |am_in|, with -128 saturated to 127; range 0..127, 7 bits.
  - v1 <= in_valid.
- Stage 2, when v1:
  - buf[wptr] <= mag_r.
  - sum <= sum + mag_r - (win_full ? buf[wptr] : 0), where buf[wptr] is the old value read the same cycle.
  - wptr increments and wraps from WIN-1 to 0.
  - fill_cnt saturates at WIN.
  - win_full goes high in the same cycle fill_cnt reaches WIN and stays high until reset or clr.
  - v2 <= v1 && (window full after this update).
- sum width: 7+LOG2_WIN bits unsigned; it never overflows and never underflows.
- Stage 3, when v2:
  - env_out <= sum >> (LOG2_WIN-1), i.e. mean magnitude x2, max 254.
  - env_valid <= v2.
- env_out holds its value between strobes.
- Latency: sample accepted in cycle t → env_valid in cycle t+3.
- First env_valid follows the WIN-th accepted sample; thereafter one strobe per accepted sample.
- in_valid gaps: the pipeline stalls naturally; no state changes without a valid; throughput is 1 sample/clk.
- clr = 1:
  - Next edge zeroes sum, wptr, fill_cnt, win_full, v1, v2, env_valid; env_out holds its last value.
  - A sample presented with in_valid in the same cycle as clr is discarded.
  - clr has priority over all other updates.
- rst_n deassertion mid-stream: restarts in the fill phase identically to clr.
- Window fill with fewer than WIN samples: no env_valid is produced.

Optional Feature:
- Macro AM_DC_BLOCK_EN.
- Defined:
  - Adds a DC blocker after stage 3: dc_est (8+DC_SHIFT bits, fractional) updates on each env_valid as dc_est <= dc_est + ((env<<DC_SHIFT) - dc_est) >>> DC_SHIFT.
  - dc_out <= env - dc_est integer part, saturated to -128..127, registered in the same cycle as env_out. No extra latency.
  - Reset and clr zero dc_est and dc_out.
- Undefined: dc_out port and all DC logic are absent; env_out behaviour is unchanged.

Test Plan:
- Reset, then 128 samples of am_in = 100 on consecutive cycles (LOG2_WIN=7) → env_valid first high 3 cycles after the 128th sample, env_out = 200, win_full high, then one strobe per further sample, each 200.
- am_in held at -128 for 200 samples → env_out = 254 on every strobe; sum reaches 127*128 = 16256 with no overflow.
- Alternating +64/-64 with in_valid high every other cycle → strobes every other cycle, env_out = 128, latency still 3 cycles from each accepted sample.
- Full window of 100, then clr asserted with in_valid=1 → that sample is dropped; win_full and env_valid go low; env_out holds 200; the next 127 samples of 50 produce no strobe; the 128th produces env_out = 100.
- AM stimulus, 1 MHz carrier at 100 MHz clk, 10 kHz modulation depth 50% → env_out tracks a 10 kHz sinusoid, max/min ratio ≈ 3 (±10%).
- With AM_DC_BLOCK_EN defined, constant am_in = 100 for 4096·2^DC_SHIFT/1024 strobes → dc_out decays from +127 toward 0, |dc_out| ≤ 1 at end. Then rst_n pulsed low mid-run → all outputs 0 next cycle.
